// File: rtl/mem_readout_arbiter.sv
// Shares one RAM port between a CPU and a byte-serial readout engine.
// Optional READOUT_CHECKSUM_EN appends an XOR checksum byte after the data.
module mem_readout_arbiter #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          WORD_COUNT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cpu_done,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wd,
  input  logic        cpu_we,
  input  logic [31:0] ram_rd,
  output logic [31:0] ram_adr,
  output logic [31:0] ram_wd,
  output logic        ram_we,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        cpu_grant,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    CPU_RUN = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    SEND    = 3'd3,
    FINISH  = 3'd4
  } state_t;

  localparam logic [15:0] LAST_IDX = (WORD_COUNT == 0) ? 16'd0 : 16'(WORD_COUNT - 1);

  state_t      state_r;
  state_t      state_s;
  state_t      empty_next_s;
  logic [15:0] word_idx_r;
  logic [1:0]  byte_idx_r;
  logic [31:0] shift_r;
  logic        xfer_s;
  logic        last_byte_s;
  logic        last_word_s;
  logic        fin_s;
  logic        nxt_word_s;

  assign xfer_s      = (state_r == SEND) && out_ready;
  assign last_byte_s = (byte_idx_r == 2'd3);
  assign last_word_s = (word_idx_r == LAST_IDX);

`ifdef READOUT_CHECKSUM_EN
  logic       csum_phase_r;
  logic [7:0] csum_r;

  // The checksum byte follows the last data byte; an empty readout goes straight to it.
  assign fin_s        = csum_phase_r;
  assign nxt_word_s   = !csum_phase_r && last_byte_s && !last_word_s;
  assign empty_next_s = SEND;

  // XOR accumulator over every data byte accepted by the sink
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_r       <= 8'h00;
      csum_phase_r <= 1'b0;
    end else if (start) begin
      csum_r       <= 8'h00;
      csum_phase_r <= 1'b0;
    end else if ((state_r == CPU_RUN) && cpu_done && (WORD_COUNT == 0)) begin
      csum_phase_r <= 1'b1;
    end else if (xfer_s && !csum_phase_r) begin
      csum_r <= csum_r ^ shift_r[7:0];
      if (last_byte_s && last_word_s) begin
        csum_phase_r <= 1'b1;
      end
    end
  end
`else
  assign fin_s        = last_byte_s && last_word_s;
  assign nxt_word_s   = last_byte_s && !last_word_s;
  assign empty_next_s = FINISH;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= CPU_RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start overrides everything, including cpu_done
  always_comb begin
    state_s = state_r;
    if (start) begin
      state_s = CPU_RUN;
    end else begin
      case (state_r)
        CPU_RUN: begin
          if (cpu_done) begin
            state_s = (WORD_COUNT == 0) ? empty_next_s : RD_REQ;
          end else begin
            state_s = CPU_RUN;
          end
        end
        RD_REQ:  state_s = RD_WAIT;
        RD_WAIT: state_s = SEND;
        SEND: begin
          if (xfer_s && fin_s) begin
            state_s = FINISH;
          end else if (xfer_s && nxt_word_s) begin
            state_s = RD_REQ;
          end else begin
            state_s = SEND;
          end
        end
        FINISH:  state_s = FINISH;
        default: state_s = CPU_RUN;
      endcase
    end
  end

  // Word/byte counters and the little-endian output shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_idx_r <= 16'd0;
      byte_idx_r <= 2'd0;
      shift_r    <= 32'h0000_0000;
    end else if (start) begin
      word_idx_r <= 16'd0;
      byte_idx_r <= 2'd0;
      shift_r    <= 32'h0000_0000;
    end else begin
      case (state_r)
        RD_WAIT: begin
          shift_r    <= ram_rd;
          byte_idx_r <= 2'd0;
        end
        SEND: begin
          if (xfer_s) begin
            shift_r    <= {8'h00, shift_r[31:8]};
            byte_idx_r <= byte_idx_r + 2'd1;
            if (nxt_word_s) begin
              word_idx_r <= word_idx_r + 16'd1;
            end
          end
        end
        default: begin
          shift_r <= shift_r;
        end
      endcase
    end
  end

  // Output decode; the RAM port is a pure mux while the CPU owns it
  always_comb begin
    cpu_grant = 1'b0;
    ram_adr   = BASE_ADDR + {16'h0000, word_idx_r};
    ram_wd    = 32'h0000_0000;
    ram_we    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    out_byte  = shift_r[7:0];
`ifdef READOUT_CHECKSUM_EN
    if (csum_phase_r) begin
      out_byte = csum_r;
    end else begin
      out_byte = shift_r[7:0];
    end
`endif
    case (state_r)
      CPU_RUN: begin
        cpu_grant = 1'b1;
        ram_adr   = cpu_adr;
        ram_wd    = cpu_wd;
        ram_we    = cpu_we;
      end
      RD_REQ:  busy = 1'b1;
      RD_WAIT: busy = 1'b1;
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      FINISH:  done = 1'b1;
      default: cpu_grant = 1'b0;
    endcase
  end

endmodule
